// File: rtl/keypad_pkg.sv
// Shared key codes, FSM encodings and key-position lookup for the keypad responder.
// Pure definitions: no clocked logic.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR  = 4'd10;
    localparam logic [3:0] KEY_HASH  = 4'd11;
    localparam logic [3:0] KEY_MAX   = 4'd11;
    localparam logic [2:0] IDLE_COLS = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_B_PRESS = 3'd1,
        S_HOLD    = 3'd2,
        S_B_REL   = 3'd3,
        S_GAP     = 3'd4
    } kp_state_e;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_pos_t;

    function automatic key_pos_t key_lookup(input logic [3:0] code);
        key_pos_t p;
        p = '{row: 2'd0, col: 2'd0};
        case (code)
            4'd1:     p = '{row: 2'd0, col: 2'd0};
            4'd2:     p = '{row: 2'd0, col: 2'd1};
            4'd3:     p = '{row: 2'd0, col: 2'd2};
            4'd4:     p = '{row: 2'd1, col: 2'd0};
            4'd5:     p = '{row: 2'd1, col: 2'd1};
            4'd6:     p = '{row: 2'd1, col: 2'd2};
            4'd7:     p = '{row: 2'd2, col: 2'd0};
            4'd8:     p = '{row: 2'd2, col: 2'd1};
            4'd9:     p = '{row: 2'd2, col: 2'd2};
            KEY_STAR: p = '{row: 2'd3, col: 2'd0};
            4'd0:     p = '{row: 2'd3, col: 2'd1};
            KEY_HASH: p = '{row: 2'd3, col: 2'd2};
            default:  p = '{row: 2'd0, col: 2'd0};
        endcase
        return p;
    endfunction

    // Toggle counter width; never below one bit so BOUNCE_N=0 still elaborates.
    function automatic int tog_w(input int n);
        return (n == 0) ? 1 : $clog2(2 * n + 1);
    endfunction

endpackage

// File: rtl/keypad_bounce_gen.sv
// Contact bounce pattern: 2*BOUNCE_N phases of BOUNCE_CYC cycles, level toggling per phase.
// Level valid the cycle after start; fin flags the final cycle of the last phase.
module keypad_bounce_gen
    import keypad_pkg::*;
#(
    parameter int HOLD_W     = 16,
    parameter int BOUNCE_N   = 3,
    parameter int BOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic init_lvl,
    output logic lvl,
    output logic fin
);

    localparam int TW = tog_w(BOUNCE_N);
    localparam logic [TW-1:0]     TOG_LAST = TW'((BOUNCE_N == 0) ? 0 : 2 * BOUNCE_N - 1);
    localparam logic [TW-1:0]     TOG_ONE  = 1;
    localparam logic [HOLD_W-1:0] PH_LAST  = HOLD_W'(BOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] PH_ONE   = 1;

    logic              act_q;
    logic              lvl_q;
    logic [HOLD_W-1:0] ph_q;
    logic [TW-1:0]     tog_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            act_q <= 1'b0;
            lvl_q <= 1'b0;
            ph_q  <= '0;
            tog_q <= '0;
        end else if (start) begin
            act_q <= 1'b1;
            lvl_q <= init_lvl;
            ph_q  <= PH_LAST;
            tog_q <= TOG_LAST;
        end else if (act_q) begin
            if (ph_q == '0) begin
                lvl_q <= ~lvl_q;
                ph_q  <= PH_LAST;
                if (tog_q == '0) begin
                    act_q <= 1'b0;
                end else begin
                    tog_q <= tog_q - TOG_ONE;
                end
            end else begin
                ph_q <= ph_q - PH_ONE;
            end
        end
    end

    assign lvl = lvl_q;
    assign fin = act_q && (ph_q == '0) && (tog_q == '0);

endmodule

// File: rtl/keypad_matrix_responder.sv
// Emulated 4x3 keypad: one press per accepted request, with bounce, returning active-low columns.
// Columns registered (1-cycle latency); requests arriving while not ready are dropped.
module keypad_matrix_responder
    import keypad_pkg::*;
#(
    parameter int HOLD_W     = 16,
    parameter int BOUNCE_N   = 3,
    parameter int BOUNCE_CYC = 4,
    parameter int GAP_CYC    = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req,
    input  logic [3:0]        key_code,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic              contact,
    output logic [7:0]        row_hits,
    input  logic [3:0]        out_singal,
    output logic [2:0]        in_key
);

    localparam bit                HAS_BNC  = (BOUNCE_N > 0);
    localparam logic [HOLD_W-1:0] CNT_ONE  = 1;
    localparam logic [HOLD_W-1:0] GAP_LAST = HOLD_W'(GAP_CYC - 1);

    kp_state_e         state_q;
    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] hold_q;
    logic [3:0]        code_q;
    logic              err_q;
    logic [7:0]        hits_q;
    logic              rowbit_q;
    logic [2:0]        cols_q;

    key_pos_t          pos;
    key_pos_t          new_pos;
    logic [1:0]        col_idx;
    logic              row_now;
    logic              code_ok;
    logic              accept;
    logic [HOLD_W-1:0] hold_d;
    logic              contact_d;
    logic              hit_d;
    logic              bnc_start;
    logic              bnc_lvl;
    logic              bnc_fin;

    assign pos       = key_lookup(code_q);
    assign new_pos   = key_lookup(key_code);
    assign col_idx   = 2'd2 - pos.col;
    assign row_now   = out_singal[~pos.row];
    assign code_ok   = (key_code <= KEY_MAX);
    assign accept    = req && (state_q == S_IDLE);
    assign hold_d    = (hold_cycles == '0) ? CNT_ONE : hold_cycles;
    assign contact_d = (state_q == S_HOLD) ||
                       (((state_q == S_B_PRESS) || (state_q == S_B_REL)) && bnc_lvl);
    assign hit_d     = contact_d && rowbit_q && !row_now;
    assign bnc_start = HAS_BNC && ((accept && code_ok) || ((state_q == S_HOLD) && (cnt_q == '0)));

    keypad_bounce_gen #(
        .HOLD_W    (HOLD_W),
        .BOUNCE_N  (BOUNCE_N),
        .BOUNCE_CYC(BOUNCE_CYC)
    ) u_bounce (
        .clk     (clk),
        .clr     (clr),
        .start   (bnc_start),
        .init_lvl(state_q == S_IDLE),
        .lvl     (bnc_lvl),
        .fin     (bnc_fin)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hold_q   <= '0;
            code_q   <= '0;
            err_q    <= 1'b0;
            hits_q   <= '0;
            rowbit_q <= 1'b1;
            cols_q   <= IDLE_COLS;
        end else begin
            err_q    <= 1'b0;
            rowbit_q <= row_now;
            cols_q   <= IDLE_COLS;
            if (contact_d && !row_now) begin
                cols_q[col_idx] <= 1'b0;
            end
            if (hit_d && (hits_q != 8'hFF)) begin
                hits_q <= hits_q + 8'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        code_q   <= key_code;
                        hold_q   <= hold_d;
                        hits_q   <= '0;
                        // Re-seed the edge detector from the new key's row.
                        rowbit_q <= out_singal[~new_pos.row];
                        if (!code_ok) begin
                            err_q <= 1'b1;
                        end else if (HAS_BNC) begin
                            state_q <= S_B_PRESS;
                        end else begin
                            state_q <= S_HOLD;
                            cnt_q   <= hold_d - CNT_ONE;
                        end
                    end
                end
                S_B_PRESS: begin
                    if (bnc_fin) begin
                        state_q <= S_HOLD;
                        cnt_q   <= hold_q - CNT_ONE;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == '0) begin
                        if (HAS_BNC) begin
                            state_q <= S_B_REL;
                        end else begin
                            state_q <= S_GAP;
                            cnt_q   <= GAP_LAST;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_B_REL: begin
                    if (bnc_fin) begin
                        state_q <= S_GAP;
                        cnt_q   <= GAP_LAST;
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign done     = (state_q == S_GAP) && (cnt_q == '0);
    assign err      = err_q;
    assign contact  = contact_d;
    assign row_hits = hits_q;
    assign in_key   = cols_q;

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Directed bench: a clean-edge instance (BOUNCE_N=0) and a default bouncing instance.
module tb_keypad_matrix_responder;

    logic        clk = 1'b0;
    logic        clr;
    logic        req0, req3;
    logic [3:0]  key_code;
    logic [3:0]  out_singal;
    logic [15:0] hold_cycles;

    logic        ready0, done0, err0, contact0;
    logic [7:0]  hits0;
    logic [2:0]  ik0;
    logic        ready3, done3, err3, contact3;
    logic [7:0]  hits3;
    logic [2:0]  ik3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    keypad_matrix_responder #(.BOUNCE_N(0)) u_dut0 (
        .clk(clk), .clr(clr), .req(req0), .key_code(key_code), .hold_cycles(hold_cycles),
        .ready(ready0), .done(done0), .err(err0), .contact(contact0), .row_hits(hits0),
        .out_singal(out_singal), .in_key(ik0)
    );

    keypad_matrix_responder u_dut3 (
        .clk(clk), .clr(clr), .req(req3), .key_code(key_code), .hold_cycles(hold_cycles),
        .ready(ready3), .done(done3), .err(err3), .contact(contact3), .row_hits(hits3),
        .out_singal(out_singal), .in_key(ik3)
    );

    typedef struct {
        logic [3:0] rows;
        logic [2:0] cols;
        logic       con;
    } seg1_t;

    typedef struct {
        logic lvl;
        int   len;
    } seg2_t;

    seg1_t t1[7];
    seg2_t t2[14];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        int c, nready, tdone, ncl, n101;
        logic prev;

        t1[0] = '{4'b0111, 3'b111, 1'b1};
        t1[1] = '{4'b1011, 3'b101, 1'b1};
        t1[2] = '{4'b1101, 3'b111, 1'b1};
        t1[3] = '{4'b1110, 3'b111, 1'b1};
        t1[4] = '{4'b0111, 3'b111, 1'b1};
        t1[5] = '{4'b1011, 3'b111, 1'b0};
        t1[6] = '{4'b1101, 3'b111, 1'b0};

        t2[0]  = '{1'b1, 4};  t2[1]  = '{1'b0, 4};  t2[2]  = '{1'b1, 4};
        t2[3]  = '{1'b0, 4};  t2[4]  = '{1'b1, 4};  t2[5]  = '{1'b0, 4};
        t2[6]  = '{1'b1, 10};
        t2[7]  = '{1'b0, 4};  t2[8]  = '{1'b1, 4};  t2[9]  = '{1'b0, 4};
        t2[10] = '{1'b1, 4};  t2[11] = '{1'b0, 4};  t2[12] = '{1'b1, 4};
        t2[13] = '{1'b0, 8};

        clr = 1'b1; req0 = 1'b0; req3 = 1'b0;
        key_code = 4'd0; hold_cycles = 16'd0; out_singal = 4'b1111;
        tick; tick;
        clr = 1'b0;
        chk("rst_ready0", ready0, 1);   chk("rst_ready3", ready3, 1);
        chk("rst_contact0", contact0, 0); chk("rst_contact3", contact3, 0);
        chk("rst_in_key0", ik0, 3'b111); chk("rst_in_key3", ik3, 3'b111);
        chk("rst_done0", done0, 0);     chk("rst_err0", err0, 0);
        chk("rst_hits0", hits0, 0);     chk("rst_hits3", hits3, 0);

        // Row walk on key 5 with clean edges.
        out_singal = 4'b0111; key_code = 4'd5; hold_cycles = 16'd20; req0 = 1'b1;
        tick;
        req0 = 1'b0;
        chk("t1_contact_start", contact0, 1);
        chk("t1_ready_busy", ready0, 0);
        for (int s = 0; s < 7; s++) begin
            for (int j = 0; j < 4; j++) begin
                out_singal = t1[s].rows;
                tick;
                chk("t1_in_key", ik0, t1[s].cols);
                if (j == 0) chk("t1_contact", contact0, t1[s].con);
                chk("t1_done", done0, (s * 4 + j) == 26);
            end
        end
        chk("t1_ready_end", ready0, 1);

        // Bouncing '#' press on the default instance.
        out_singal = 4'b1110; key_code = 4'd11; hold_cycles = 16'd10; req3 = 1'b1;
        tick;
        req3 = 1'b0;
        c = 0; prev = 1'b0;
        for (int s = 0; s < 14; s++) begin
            for (int j = 0; j < t2[s].len; j++) begin
                c++;
                chk("t2_contact", contact3, t2[s].lvl);
                chk("t2_in_key", ik3, prev ? 3'b110 : 3'b111);
                chk("t2_done", done3, c == 66);
                prev = t2[s].lvl;
                tick;
            end
        end
        chk("t2_ready_end", ready3, 1);
        chk("t2_done_end", done3, 0);
        chk("t2_hits", hits3, 0);

        // Invalid code.
        out_singal = 4'b0000; key_code = 4'd12; hold_cycles = 16'd5; req0 = 1'b1;
        tick;
        req0 = 1'b0;
        chk("t3_err_pulse", err0, 1);
        chk("t3_ready", ready0, 1);
        tick;
        chk("t3_err_clear", err0, 0);
        for (int k = 0; k < 10; k++) begin
            chk("t3_in_key", ik0, 3'b111);
            chk("t3_contact", contact0, 0);
            tick;
        end

        // Reset during HOLD, then clr+req collision, then a normal press.
        out_singal = 4'b1111; key_code = 4'd1; hold_cycles = 16'd20; req0 = 1'b1;
        tick;
        req0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            out_singal = (k % 2 == 0) ? 4'b0111 : 4'b1111;
            tick;
            chk("t4_in_key", ik0, (k % 2 == 0) ? 3'b011 : 3'b111);
        end
        chk("t4_hits_pre", hits0, 2);
        clr = 1'b1;
        tick;
        clr = 1'b0;
        chk("t4_clr_in_key", ik0, 3'b111);
        chk("t4_clr_ready", ready0, 1);
        chk("t4_clr_hits", hits0, 0);
        chk("t4_clr_contact", contact0, 0);
        clr = 1'b1; req0 = 1'b1;
        tick;
        clr = 1'b0; req0 = 1'b0;
        chk("t4_clrreq_ready", ready0, 1);
        chk("t4_clrreq_contact", contact0, 0);
        out_singal = 4'b0000; key_code = 4'd0; hold_cycles = 16'd3; req0 = 1'b1;
        tick;
        req0 = 1'b0;
        chk("t4_k0_contact", contact0, 1);
        tick;
        chk("t4_k0_in_key", ik0, 3'b101);
        c = 2;
        while (!done0 && c < 50) begin
            tick;
            c++;
        end
        chk("t4_k0_done_cycle", c, 11);
        tick;
        chk("t4_k0_ready", ready0, 1);

        // req held high across a busy press.
        out_singal = 4'b1111; key_code = 4'd2; hold_cycles = 16'd5; req0 = 1'b1;
        tick;
        nready = 0; tdone = 0;
        for (c = 1; c <= 14; c++) begin
            if (ready0) nready++;
            if (done0 && tdone == 0) tdone = c;
            tick;
        end
        chk("t5_done_cycle", tdone, 13);
        chk("t5_ready_cycles", nready, 1);
        chk("t5_second_accept", ready0, 0);
        req0 = 1'b0;
        for (int k = 0; k < 40 && !ready0; k++) tick;
        chk("t5_second_done", ready0, 1);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("t5_no_third", ready0, 1);
        end

        // Zero hold, static low row, then saturation.
        out_singal = 4'b1101; key_code = 4'd8; hold_cycles = 16'd0; req0 = 1'b1;
        tick;
        req0 = 1'b0;
        ncl = 0; n101 = 0;
        for (int k = 0; k < 15; k++) begin
            if (contact0) ncl++;
            if (ik0 == 3'b101) n101++;
            tick;
        end
        chk("t6_closed_cycles", ncl, 1);
        chk("t6_col_pulses", n101, 1);
        chk("t6_hits_static", hits0, 0);
        chk("t6_ready", ready0, 1);
        out_singal = 4'b1111; hold_cycles = 16'd700; req0 = 1'b1;
        tick;
        req0 = 1'b0;
        for (int k = 0; k < 600; k++) begin
            out_singal = (k % 2 == 0) ? 4'b1101 : 4'b1111;
            tick;
            if (k == 19) chk("t6_hits_10", hits0, 10);
        end
        chk("t6_hits_sat", hits0, 255);
        chk("t6_still_closed", contact0, 1);
        clr = 1'b1;
        tick;
        clr = 1'b0;
        chk("t6_clr_hits", hits0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
